text_renderer: RTL

- Consumer end of the character-RAM video readout port.
- Converts the HDMI timing generator's pixel coordinates into character-RAM addresses and fetches char/attr bytes.
- Looks up glyph rows in the 8x8 font ROM and emits 24-bit RGB plus delayed sync/DE to the TMDS encoder.
- Screen is 640x480 as an 80x30 grid of 8x16 cells; each 8x8 glyph row is shown twice vertically. The block also draws the hardware cursor and handles blink.

---
 rtl/text_video_pkg.sv | 28 ++
 rtl/text_pipe_delay.sv | 27 ++
 rtl/text_renderer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/text_video_pkg.sv
// Shared constants for the 80x30 text-mode renderer: screen geometry,
// attribute byte layout and the 16-colour CGA palette.
// Pure declarations; no ports, no state.
package text_video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COLS     = 80;
  localparam int ROWS     = 30;
  localparam int CELL_W   = 8;
  localparam int CELL_H   = 16;
  localparam int PIPE_LAT = 5;

  // Attribute byte: [3:0] foreground, [6:4] background, [7] blink
  localparam int ATTR_FG_HI = 3;
  localparam int ATTR_BG_LO = 4;
  localparam int ATTR_BG_HI = 6;
  localparam int ATTR_BLINK = 7;

  // CGA palette, entry n at PALETTE[n], {R,G,B}
  localparam logic [15:0][23:0] PALETTE = {
    24'hFFFFFF, 24'hFFFF55, 24'hFF55FF, 24'hFF5555,  // 15..12
    24'h55FFFF, 24'h55FF55, 24'h5555FF, 24'h555555,  // 11..8
    24'hAAAAAA, 24'hAA5500, 24'hAA00AA, 24'hAA0000,  // 7..4
    24'h00AAAA, 24'h00AA00, 24'h0000AA, 24'h000000   // 3..0
  };

endpackage

// File: rtl/text_pipe_delay.sv
// Fixed-depth shift register for side-band alignment.
// Latency DEPTH clocks; no backpressure, shifts every clock.
// Ports: clk, rst_n (sync, active-low, clears all stages), d in, q out.
module text_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/text_renderer.sv
// Text-mode video renderer: pixel coordinates -> char RAM -> font ROM -> RGB.
// Latency 5 clocks pixel-in to rgb_o/de_o/hsync_o/vsync_o; no backpressure.
// Ports: timing in (pixel_x/y, de_i, hsync_i, vsync_i), char RAM port
// (video_char_addr, video_char_data, video_attr_data), font ROM port
// (font_addr, font_data), cursor controls, RGB + delayed sync out.
module text_renderer
  import text_video_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic [11:0] video_char_addr,
  input  logic [7:0]  video_char_data,
  input  logic [7:0]  video_attr_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic [23:0] rgb_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  // ---------------- S1: address generation ----------------
  logic        in_active;
  logic [11:0] row12;
  logic [11:0] addr_calc;
  logic        cur_hit;

  assign in_active = de_i && (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 10'(V_ACTIVE));
  assign row12     = {7'd0, pixel_y[8:4]};
  // row*80 as (row<<6)+(row<<4)
  assign addr_calc = (row12 << 6) + (row12 << 4) + {5'd0, pixel_x[9:3]};
  assign cur_hit   = cursor_en && (pixel_x[9:3] == cursor_x) && (pixel_y[8:4] == cursor_y);

  logic [2:0] col_s1, grow_s1;
  logic       cur_s1, lrow_s1, de_s1, hs_s1, vs_s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      video_char_addr <= '0;
      col_s1  <= '0;
      grow_s1 <= '0;
      cur_s1  <= 1'b0;
      lrow_s1 <= 1'b0;
      de_s1   <= 1'b0;
      hs_s1   <= 1'b0;
      vs_s1   <= 1'b0;
    end else begin
      video_char_addr <= in_active ? addr_calc : 12'd0;
      col_s1  <= pixel_x[2:0];
      grow_s1 <= pixel_y[3:1];          // 8x8 glyph row, each doubled
      cur_s1  <= cur_hit;
      lrow_s1 <= (pixel_y[3:1] == 3'd7); // bottom two scanlines of the cell
      de_s1   <= in_active;
      hs_s1   <= hsync_i;
      vs_s1   <= vsync_i;
    end
  end

  // ---------------- side-band alignment ----------------
  // Glyph row is needed at S3 (font address), the rest at the S5 decision.
  logic [2:0] grow_s2;
  logic [2:0] col_s4;
  logic       cur_s4, lrow_s4, de_s4, hs_s4, vs_s4;

  text_pipe_delay #(.WIDTH(3), .DEPTH(1)) u_grow_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (grow_s1),
    .q     (grow_s2)
  );

  text_pipe_delay #(.WIDTH(8), .DEPTH(3)) u_side_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({col_s1, cur_s1, lrow_s1, de_s1, hs_s1, vs_s1}),
    .q     ({col_s4, cur_s4, lrow_s4, de_s4, hs_s4, vs_s4})
  );

  // ---------------- S3/S4: font address, attribute ----------------
  logic [7:0] attr_s3, attr_s4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      font_addr <= '0;
      attr_s3   <= '0;
      attr_s4   <= '0;
    end else begin
      font_addr <= {video_char_data, grow_s2};
      attr_s3   <= video_attr_data;
      attr_s4   <= attr_s3;
    end
  end

  // ---------------- frame counter ----------------
  // The registered copy tracks vsync_i even in reset, so a vsync already
  // high at release is not seen as a rising edge.
  logic [5:0] frame_cnt;
  logic       vsync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      vsync_q   <= vsync_i;
    end else begin
      vsync_q <= vsync_i;
      if (vsync_i && !vsync_q) frame_cnt <= frame_cnt + 6'd1;
    end
  end

  // ---------------- S5: pixel decision ----------------
  logic        pix_bit, blink_off, pix_on;
  logic [23:0] rgb_next;

  always_comb begin
    pix_bit   = font_data[3'd7 - col_s4];
    blink_off = attr_s4[ATTR_BLINK] && frame_cnt[5];
    pix_on    = pix_bit && !blink_off;
    // Underline cursor flashes at twice the text-blink rate
    if (cur_s4 && lrow_s4 && frame_cnt[4]) pix_on = !pix_on;
    rgb_next = 24'h000000;
    if (de_s4) begin
      rgb_next = pix_on ? PALETTE[attr_s4[ATTR_FG_HI:0]]
                        : PALETTE[{1'b0, attr_s4[ATTR_BG_HI:ATTR_BG_LO]}];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_o   <= '0;
      de_o    <= 1'b0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      rgb_o   <= rgb_next;
      de_o    <= de_s4;
      hsync_o <= hs_s4;
      vsync_o <= vs_s4;
    end
  end

endmodule
